// File: rtl/ft_fifo_emu_if.sv
// FT245-style control strobes, status flags and host stream port of the FIFO bus emulator.
// The slave modport is the emulator's view; the master modport is the FTDI master plus host.
interface ft_fifo_emu_if #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DW         = 32
);
    logic                  TXE_N;
    logic                  RXF_N;
    logic                  OE_N;
    logic                  RD_N;
    logic                  WR_N;
    logic                  host_wr_valid;
    logic [DW-1:0]         host_wr_data;
    logic                  host_wr_ready;
    logic                  host_rd_valid;
    logic [DW-1:0]         host_rd_data;
    logic                  host_rd_ready;
    logic                  stall_rx;
    logic                  stall_tx;
    logic [DEPTH_LOG2:0]   rx_count;
    logic [DEPTH_LOG2:0]   tx_count;
    logic                  proto_err;

    modport slave (
        output TXE_N, RXF_N, host_wr_ready, host_rd_valid, host_rd_data,
               rx_count, tx_count, proto_err,
        input  OE_N, RD_N, WR_N, host_wr_valid, host_wr_data, host_rd_ready,
               stall_rx, stall_tx
    );

    modport master (
        input  TXE_N, RXF_N, host_wr_ready, host_rd_valid, host_rd_data,
               rx_count, tx_count, proto_err,
        output OE_N, RD_N, WR_N, host_wr_valid, host_wr_data, host_rd_ready,
               stall_rx, stall_tx
    );
endinterface

// File: rtl/ft_fifo_emu.sv
// FT60x device-side emulator: RX (host->master) and TX (master->host) FIFOs, FWFT, flags one cycle late.
// Backpressure via RXF_N/TXE_N on the bus side and host_wr_ready/host_rd_valid on the host side.
module ft_fifo_emu #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DW         = 32
) (
    input  logic            ft_clk,
    input  logic            sys_rst,
    inout  wire [DW-1:0]    DATA,
    inout  wire [DW/8-1:0]  BE,
    ft_fifo_emu_if.slave    bus
);
    localparam int BW    = DW / 8;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2+1)'(DEPTH);

    typedef enum logic [1:0] {B_IDLE, B_RD_TURN, B_RD_BURST, B_WR} bstate_t;

    bstate_t r_bstate;
    bstate_t w_bstate_nxt;
    logic    w_in_idle;

    logic [DW-1:0]         r_rx_mem [DEPTH];
    logic [DW-1:0]         r_tx_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] r_rx_wp, r_rx_rp, r_tx_wp, r_tx_rp;
    logic [DEPTH_LOG2:0]   r_rx_cnt, r_tx_cnt;
    logic [DEPTH_LOG2:0]   w_rx_cnt_nxt, w_tx_cnt_nxt;
    logic                  r_rxf_n, r_txe_n, r_proto_err, r_live;

    logic          w_rx_push, w_rx_pop, w_tx_push, w_tx_pop;
    logic          w_drive, w_err;
    logic [DW-1:0] w_rx_head, w_wr_masked;

    // Guards on counts make over/underflow impossible even if flags and stalls disagree.
    assign w_rx_pop  = ~bus.OE_N & ~bus.RD_N & ~r_rxf_n & (r_rx_cnt != '0);
    assign w_rx_push = bus.host_wr_valid & bus.host_wr_ready;
    assign w_tx_push = ~bus.WR_N & bus.OE_N & ~r_txe_n & (r_tx_cnt != FULL);
    assign w_tx_pop  = bus.host_rd_valid & bus.host_rd_ready;

    assign w_rx_cnt_nxt = r_rx_cnt + (DEPTH_LOG2+1)'(w_rx_push) - (DEPTH_LOG2+1)'(w_rx_pop);
    assign w_tx_cnt_nxt = r_tx_cnt + (DEPTH_LOG2+1)'(w_tx_push) - (DEPTH_LOG2+1)'(w_tx_pop);

    assign w_err = (~bus.RD_N & r_rxf_n)
                 | (~bus.WR_N & r_txe_n)
                 | (~bus.OE_N & ~bus.WR_N)
                 | (~bus.RD_N & w_in_idle);

    always_comb begin
        w_wr_masked = '0;
        for (int i = 0; i < BW; i++) begin
            if (BE[i]) w_wr_masked[i*8 +: 8] = DATA[i*8 +: 8];
        end
    end

    // Bus is released throughout reset and until the first live cycle.
    assign w_rx_head = (r_rx_cnt != '0) ? r_rx_mem[r_rx_rp] : '0;
    assign w_drive   = ~bus.OE_N & r_live & ~sys_rst;
    assign DATA      = w_drive ? w_rx_head : {DW{1'bz}};
    assign BE        = w_drive ? {BW{1'b1}} : {BW{1'bz}};

    assign bus.RXF_N         = r_rxf_n;
    assign bus.TXE_N         = r_txe_n;
    assign bus.proto_err     = r_proto_err;
    assign bus.rx_count      = r_rx_cnt;
    assign bus.tx_count      = r_tx_cnt;
    assign bus.host_wr_ready = r_live & (r_rx_cnt != FULL);
    assign bus.host_rd_valid = (r_tx_cnt != '0);
    assign bus.host_rd_data  = (r_tx_cnt != '0) ? r_tx_mem[r_tx_rp] : '0;

    always_ff @(posedge ft_clk) begin
        if (sys_rst) begin
            r_rx_wp     <= '0;
            r_rx_rp     <= '0;
            r_tx_wp     <= '0;
            r_tx_rp     <= '0;
            r_rx_cnt    <= '0;
            r_tx_cnt    <= '0;
            r_rxf_n     <= 1'b1;
            r_txe_n     <= 1'b1;
            r_proto_err <= 1'b0;
            r_live      <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (w_rx_push) r_rx_wp <= r_rx_wp + DEPTH_LOG2'(1);
            if (w_rx_pop)  r_rx_rp <= r_rx_rp + DEPTH_LOG2'(1);
            if (w_tx_push) r_tx_wp <= r_tx_wp + DEPTH_LOG2'(1);
            if (w_tx_pop)  r_tx_rp <= r_tx_rp + DEPTH_LOG2'(1);
            r_rx_cnt <= w_rx_cnt_nxt;
            r_tx_cnt <= w_tx_cnt_nxt;
            r_rxf_n  <= (w_rx_cnt_nxt == '0) | bus.stall_rx;
            r_txe_n  <= (w_tx_cnt_nxt == FULL) | bus.stall_tx;
            if (w_err) r_proto_err <= 1'b1;
        end
    end

    always_ff @(posedge ft_clk) begin
        if (w_rx_push) r_rx_mem[r_rx_wp] <= bus.host_wr_data;
        if (w_tx_push) r_tx_mem[r_tx_wp] <= w_wr_masked;
    end

    always_ff @(posedge ft_clk) begin
        if (sys_rst) r_bstate <= B_IDLE;
        else         r_bstate <= w_bstate_nxt;
    end

    always_comb begin
        w_bstate_nxt = r_bstate;
        case (r_bstate)
            B_IDLE: begin
                if (~bus.OE_N)      w_bstate_nxt = B_RD_TURN;
                else if (~bus.WR_N) w_bstate_nxt = B_WR;
            end
            B_RD_TURN: begin
                if (~bus.RD_N)     w_bstate_nxt = B_RD_BURST;
                else if (bus.OE_N) w_bstate_nxt = B_IDLE;
            end
            B_RD_BURST: if (bus.OE_N) w_bstate_nxt = B_IDLE;
            B_WR:       if (bus.WR_N) w_bstate_nxt = B_IDLE;
            default:    w_bstate_nxt = B_IDLE;
        endcase
    end

    always_comb begin
        w_in_idle = (r_bstate == B_IDLE);
    end
endmodule

// File: tb/tb_ft_fifo_emu.sv
// Directed + randomized bench for ft_fifo_emu against a queue-based model of the FT245 device rules.
module tb_ft_fifo_emu;
    localparam int PH_IDLE = 0;
    localparam int PH_TURN = 1;
    localparam int PH_READ = 2;
    localparam int PH_WRIT = 3;

    logic ft_clk = 1'b0;
    logic sys_rst;
    wire [31:0] DATA;
    wire [3:0]  BE;
    logic        tb_drv;
    logic [31:0] tb_dat;
    logic [3:0]  tb_be;

    always #5 ft_clk = ~ft_clk;

    assign DATA = tb_drv ? tb_dat : 32'hzzzz_zzzz;
    assign BE   = tb_drv ? tb_be  : 4'hz;

    ft_fifo_emu_if #(.DEPTH_LOG2(4), .DW(32)) bus ();

    ft_fifo_emu #(.DEPTH_LOG2(4), .DW(32)) dut (
        .ft_clk  (ft_clk),
        .sys_rst (sys_rst),
        .DATA    (DATA),
        .BE      (BE),
        .bus     (bus.slave)
    );

    logic [31:0] rxq[$];
    logic [31:0] txq[$];
    bit          m_rxf_n, m_txe_n, m_err, m_live;
    int          m_phase;
    int          checks = 0;
    int          errors = 0;

    function automatic logic [31:0] mask_be(input logic [31:0] d, input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (!b[i]) d[i*8 +: 8] = 8'h00;
        return d;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Applies the device rules to the inputs present before the edge, then advances one cycle.
    task automatic tick();
        bit bus_pop, bus_push, h_push, h_pop;
        if (sys_rst) begin
            rxq.delete();
            txq.delete();
            m_rxf_n = 1; m_txe_n = 1; m_err = 0; m_live = 0; m_phase = PH_IDLE;
        end else begin
            bus_pop  = !bus.OE_N && !bus.RD_N && !m_rxf_n;
            bus_push = !bus.WR_N && bus.OE_N && !m_txe_n;
            h_push   = bus.host_wr_valid && m_live && rxq.size() < 16;
            h_pop    = bus.host_rd_ready && txq.size() > 0;
            if ((!bus.RD_N && m_rxf_n) || (!bus.WR_N && m_txe_n) ||
                (!bus.OE_N && !bus.WR_N) || (!bus.RD_N && m_phase == PH_IDLE))
                m_err = 1;
            case (m_phase)
                PH_IDLE: if (!bus.OE_N) m_phase = PH_TURN; else if (!bus.WR_N) m_phase = PH_WRIT;
                PH_TURN: if (!bus.RD_N) m_phase = PH_READ; else if (bus.OE_N) m_phase = PH_IDLE;
                PH_READ: if (bus.OE_N) m_phase = PH_IDLE;
                default: if (bus.WR_N) m_phase = PH_IDLE;
            endcase
            if (bus_pop)  void'(rxq.pop_front());
            if (h_push)   rxq.push_back(bus.host_wr_data);
            if (h_pop)    void'(txq.pop_front());
            if (bus_push) txq.push_back(mask_be(tb_dat, tb_be));
            m_rxf_n = (rxq.size() == 0) || bus.stall_rx;
            m_txe_n = (txq.size() == 16) || bus.stall_tx;
            m_live  = 1;
        end
        @(posedge ft_clk);
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".rxf"},   bus.RXF_N, m_rxf_n);
        chk({tag, ".txe"},   bus.TXE_N, m_txe_n);
        chk({tag, ".err"},   bus.proto_err, m_err);
        chk({tag, ".rxcnt"}, bus.rx_count, rxq.size());
        chk({tag, ".txcnt"}, bus.tx_count, txq.size());
        chk({tag, ".wrrdy"}, bus.host_wr_ready, (m_live && rxq.size() < 16));
        chk({tag, ".rdvld"}, bus.host_rd_valid, (txq.size() > 0));
        if (txq.size() > 0) chk({tag, ".rddat"}, bus.host_rd_data, txq[0]);
        if (!sys_rst && m_live && bus.OE_N == 1'b0)
            chk({tag, ".data"}, DATA, (rxq.size() > 0) ? rxq[0] : 32'h0);
    endtask

    initial begin
        logic [31:0] cap;
        int          taken;

        sys_rst = 1;
        bus.OE_N = 1; bus.RD_N = 1; bus.WR_N = 1;
        bus.host_wr_valid = 0; bus.host_wr_data = '0; bus.host_rd_ready = 0;
        bus.stall_rx = 0; bus.stall_tx = 0;
        tb_drv = 0; tb_dat = '0; tb_be = '0;

        // Reset state and first post-reset cycle
        tick(); tick();
        check_all("rst");
        chk("rst_txe", bus.TXE_N, 1);
        chk("rst_wrrdy", bus.host_wr_ready, 0);
        sys_rst = 0;
        tick();
        check_all("rel");
        chk("rel_txe", bus.TXE_N, 0);

        // Host loads three words
        for (int i = 0; i < 3; i++) begin
            bus.host_wr_valid = 1;
            bus.host_wr_data  = 32'hA000_0001 + i;
            tick();
            check_all("hpush");
            if (i == 0) chk("rxf_first", bus.RXF_N, 0);
        end
        bus.host_wr_valid = 0;
        chk("rxcnt3", bus.rx_count, 3);

        // Master turnaround then a 3-word read burst
        bus.OE_N = 0;
        tick();
        check_all("turn");
        bus.RD_N = 0;
        for (int i = 0; i < 3; i++) begin
            cap = DATA;
            chk("rd_word", cap, 32'hA000_0001 + i);
            tick();
            check_all("pop");
        end
        bus.RD_N = 1; bus.OE_N = 1;
        chk("rxf_after3", bus.RXF_N, 1);
        chk("err_clean", bus.proto_err, 0);
        tick();
        check_all("rd_end");

        // Single masked write
        tb_drv = 1; tb_dat = 32'h1234_5678; tb_be = 4'b0011; bus.WR_N = 0;
        tick();
        bus.WR_N = 1; tb_drv = 0;
        check_all("wr1");
        chk("wr1_dat", bus.host_rd_data, 32'h0000_5678);
        chk("wr1_vld", bus.host_rd_valid, 1);
        chk("wr1_cnt", bus.tx_count, 1);
        tick();
        bus.host_rd_ready = 1;
        tick();
        bus.host_rd_ready = 0;
        check_all("drain1");

        // 17 writes into a stalled host: full flag, then overrun
        tb_drv = 1; bus.WR_N = 0;
        for (int i = 0; i < 17; i++) begin
            tb_dat = $urandom;
            tb_be  = 4'($urandom_range(0, 15));
            tick();
            check_all("wr17");
            if (i == 15) chk("txe_full", bus.TXE_N, 1);
        end
        bus.WR_N = 1; tb_drv = 0;
        chk("ovr_err", bus.proto_err, 1);
        chk("tx16", bus.tx_count, 16);
        tick();
        check_all("wr17_end");
        bus.host_rd_ready = 1;
        for (int i = 0; i < 16; i++) begin
            tick();
            check_all("txdrain");
        end
        bus.host_rd_ready = 0;
        sys_rst = 1; tick(); sys_rst = 0; tick();
        check_all("rst2");

        // Concurrent host push and master pop at occupancy 5, across pointer wrap
        bus.host_wr_valid = 1;
        for (int i = 0; i < 5; i++) begin
            bus.host_wr_data = $urandom;
            tick();
        end
        bus.host_wr_valid = 0;
        bus.OE_N = 0;
        tick();
        check_all("wrap_turn");
        bus.RD_N = 0; bus.host_wr_valid = 1;
        for (int i = 0; i < 20; i++) begin
            bus.host_wr_data = $urandom;
            cap = DATA;
            chk("wrap_word", cap, rxq[0]);
            tick();
            check_all("wrap");
            chk("wrap_cnt", bus.rx_count, 5);
        end
        bus.RD_N = 1; bus.OE_N = 1; bus.host_wr_valid = 0;
        tick();
        check_all("wrap_end");

        // stall_rx raised after the second word of a 4-word burst
        sys_rst = 1; tick(); sys_rst = 0; tick();
        bus.host_wr_valid = 1;
        for (int i = 0; i < 4; i++) begin
            bus.host_wr_data = $urandom;
            tick();
        end
        bus.host_wr_valid = 0;
        bus.OE_N = 0;
        tick();
        bus.RD_N = 0;
        taken = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.RXF_N) break;
            cap = DATA;
            chk("stall_word", cap, rxq[0]);
            tick();
            check_all("stall");
            taken++;
            if (taken == 2) bus.stall_rx = 1;
        end
        bus.RD_N = 1;
        chk("stall_taken", (taken == 2 || taken == 3), 1);
        chk("stall_left", bus.rx_count, 4 - taken);
        chk("stall_rxf", bus.RXF_N, 1);
        chk("stall_err", bus.proto_err, 0);
        // Underrun while stalled: no pop, error latches
        bus.RD_N = 0;
        tick();
        bus.RD_N = 1;
        check_all("undr");
        chk("undr_err", bus.proto_err, 1);
        chk("undr_cnt", bus.rx_count, 4 - taken);
        bus.stall_rx = 0; bus.OE_N = 1;
        tick();
        check_all("unstall");
        chk("unstall_rxf", bus.RXF_N, 0);

        // Reset with four words queued while the master requests the bus
        bus.host_wr_valid = 1;
        while (bus.rx_count < 4) begin
            bus.host_wr_data = $urandom;
            tick();
        end
        bus.host_wr_valid = 0;
        chk("q4", bus.rx_count, 4);
        sys_rst = 1; bus.OE_N = 0;
        tb_drv = 1; tb_dat = $urandom; tb_be = 4'b0000;
        tick();
        check_all("rst4");
        chk("rst4_cnt", bus.rx_count, 0);
        chk("rst4_rxf", bus.RXF_N, 1);
        chk("rst4_be_released", BE, 4'b0000);
        chk("rst4_data_released", DATA, tb_dat);
        tb_drv = 0; bus.OE_N = 1; sys_rst = 0;
        tick();
        check_all("rst4_rel");

        // RD_N without a preceding OE_N turnaround
        bus.host_wr_valid = 1; bus.host_wr_data = $urandom;
        tick();
        bus.host_wr_valid = 0;
        bus.RD_N = 0;
        tick();
        bus.RD_N = 1;
        check_all("idle_rd");
        chk("idle_rd_err", bus.proto_err, 1);
        chk("idle_rd_cnt", bus.rx_count, 1);

        // Contention: OE_N and WR_N low together never pushes
        sys_rst = 1; tick(); sys_rst = 0; tick();
        bus.OE_N = 0; bus.WR_N = 0;
        tick();
        bus.OE_N = 1; bus.WR_N = 1;
        check_all("cont");
        chk("cont_err", bus.proto_err, 1);
        chk("cont_tx", bus.tx_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ft_fifo_emu.md
Name: ft_fifo_emu

Overview:
- Synthesizable emulator of the FT60x device side of the 245 synchronous FIFO bus.
- It is the responder that the FPGA-side FTDI transceiver master talks to. It drives TXE_N/RXF_N, obeys OE_N/RD_N/WR_N, and sources or sinks DATA/BE.
- A host-side stream port loads words for the master to read and drains words the master has written.
- Used for on-chip loopback and in benches in place of the physical FTDI part.

Parameters:
- DEPTH_LOG2, 4, log2 of each internal FIFO depth (16 words).
- DW, 32, data bus width; BE width is DW/8.

Ports:
- ft_clk  in  1  single clock, shared with the master.
- sys_rst  in  1  synchronous, active-high reset.
- TXE_N  out  1  low when the TX FIFO (master->host) can accept a word.
- RXF_N  out  1  low when the RX FIFO (host->master) holds data.
- OE_N  in  1  from the master; low gives the bus to the emulator.
- RD_N  in  1  from the master; low means pop on this edge.
- WR_N  in  1  from the master; low means push on this edge.
- DATA  inout  DW  FIFO data bus.
- BE  inout  DW/8  byte enables.
- host_wr_valid  in  1  host word valid for the RX FIFO.
- host_wr_data  in  DW  host word.
- host_wr_ready  out  1  RX FIFO not full.
- host_rd_valid  out  1  TX FIFO head valid.
- host_rd_data  out  DW  TX FIFO head word, first-word-fall-through.
- host_rd_ready  in  1  host consumes the TX head.
- stall_rx  in  1  forces RXF_N high.
- stall_tx  in  1  forces TXE_N high.
- rx_count  out  DEPTH_LOG2+1  RX FIFO occupancy.
- tx_count  out  DEPTH_LOG2+1  TX FIFO occupancy.
- proto_err  out  1  sticky protocol violation flag.

Behaviour:
- Reset (sys_rst=1 at an edge):
  - Both FIFOs empty, counts 0, pointers 0.
  - RXF_N=1, TXE_N=1, proto_err=0, host_rd_valid=0, host_wr_ready=0.
  - DATA and BE tri-stated.
  - Reset mid-transfer discards all FIFO contents and any in-flight word.
- Status flags are registers computed from next-cycle occupancy:
  - RXF_N <= (rx_count_next==0) | stall_rx
  - TXE_N <= (tx_count_next==2^DEPTH_LOG2) | stall_tx
  - Both become valid one cycle after reset release. TXE_N goes 0 on the first post-reset cycle.
- Bus ownership is combinational:
  - OE_N=0: drive DATA=RX head word, BE=all ones.
  - OE_N=1: DATA and BE are Z.
  - With RX empty and OE_N=0, drive DATA=0.
- Read pop: on an edge with OE_N=0, RD_N=0 and RXF_N=0, pop the RX head. The next word appears on DATA after that edge (FWFT).
- Write push: on an edge with WR_N=0, OE_N=1 and TXE_N=0, push DATA into the TX FIFO. Bytes with BE[i]=0 are stored as 0x00.
- Bus FSM, tracks master phases:
  - B_IDLE: OE_N=0 -> B_RD_TURN. WR_N=0 -> B_WR.
  - B_RD_TURN: RD_N=0 -> B_RD_BURST. OE_N=1 -> B_IDLE.
  - B_RD_BURST: OE_N=1 -> B_IDLE.
  - B_WR: WR_N=1 -> B_IDLE.
- proto_err is set, and stays set until reset, on any of:
  - RD_N=0 with RXF_N=1 (underrun); no pop occurs.
  - WR_N=0 with TXE_N=1 (overrun); the word is dropped.
  - OE_N=0 together with WR_N=0 (contention); no push occurs.
  - RD_N=0 while in B_IDLE (RD_N without a preceding OE_N turnaround cycle).
- Host side:
  - Push to RX when host_wr_valid & host_wr_ready.
  - Pop from TX when host_rd_valid & host_rd_ready.
  - host_wr_ready = RX not full.
  - host_rd_valid = TX not empty.
- Simultaneous push and pop on the same FIFO: both take effect and the count is unchanged.
  - A push into a full FIFO that is popped in the same cycle is still refused; host_wr_ready is based on current occupancy.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. Counts saturate neither way; guards make over/underflow impossible.
- stall_rx asserted mid-burst: RXF_N rises the next cycle. A pop at that next edge is an underrun.

Test Plan:
- Reset, then host pushes 0xA0000001..0xA0000003 -> RXF_N=0 one cycle after the first push; rx_count=3.
- Master pulls with OE_N=0 one cycle, then RD_N=0 for 3 cycles -> captures 0xA0000001, 0xA0000002, 0xA0000003 in order; RXF_N=1 after the third pop; proto_err=0.
- Master writes 0x12345678 with BE=4'b0011 -> host_rd_data=0x00005678, host_rd_valid=1, tx_count=1.
- Master writes 17 words with host_rd_ready=0 -> TXE_N=1 after the 16th push; the 17th WR_N pulse sets proto_err and tx_count stays 16.
- Concurrent host push and master pop at rx_count=5 -> rx_count stays 5 and data order is preserved across pointer wrap (index 15 -> 0).
- stall_rx asserted during a 4-word burst after word 2 -> RXF_N=1 next cycle; the master ends the burst with 2 or 3 words taken and the remaining words stay in the FIFO.
- Assert sys_rst with 4 words queued -> rx_count=0, RXF_N=1, DATA=Z.
